pmc_counter_bank: RTL and testbench

Parametrised performance-monitor counter bank, the successor to the fixed-function PMC unit in the processor metrics path. It holds NUM_CHANNELS programmable counters, each selecting one of NUM_EVENTS single-bit pipeline event strobes (stall, ALU op, memory read/write, branch, and so on). Counters support wrap or saturate mode, sticky overflow, global freeze, an atomic snapshot, and a registered read port that zero-extends results to the vector-register width.

---
 rtl/pmc_counter_bank.sv | 170 +++++++++++++++++
 tb/tb_pmc_counter_bank.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmc_counter_bank.sv
// pmc_counter_bank: programmable performance-monitor counter bank with wrap/saturate counters,
// sticky overflow, freeze, snapshot shadows and a registered read port. Macro: PMC_THRESHOLD_IRQ_EN.
module pmc_counter_bank #(
    parameter int NUM_CHANNELS = 8,
    parameter int NUM_EVENTS   = 16,
    parameter int CNT_WIDTH    = 32,
    parameter int VEC_WIDTH    = 256,
    localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    localparam int EV_W = $clog2(NUM_EVENTS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_EVENTS-1:0]   evt_in,
    input  logic                    cfg_we,
    input  logic [CH_W-1:0]         cfg_ch,
    input  logic [EV_W-1:0]         cfg_evt_sel,
    input  logic                    cfg_en,
    input  logic                    cfg_sat,
    input  logic                    freeze,
    input  logic                    clear,
    input  logic                    snapshot,
    input  logic                    rd_en,
    input  logic [CH_W-1:0]         rd_ch,
    input  logic                    rd_src,
    output logic                    rd_valid,
    output logic [VEC_WIDTH-1:0]    rd_data,
    output logic [NUM_CHANNELS-1:0] ovf,
    output logic [NUM_CHANNELS-1:0] irq,
    input  logic                    thr_we,
    input  logic [CH_W-1:0]         thr_ch,
    input  logic [CNT_WIDTH-1:0]    thr_val,
    input  logic [NUM_CHANNELS-1:0] irq_ack
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [CNT_WIDTH-1:0]    cnt_r     [NUM_CHANNELS];
    logic [CNT_WIDTH-1:0]    shd_r     [NUM_CHANNELS];
    logic [EV_W-1:0]         sel_r     [NUM_CHANNELS];
    logic [CNT_WIDTH-1:0]    cnt_nxt_s [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] en_r;
    logic [NUM_CHANNELS-1:0] sat_r;
    logic [NUM_CHANNELS-1:0] ovf_r;
    logic [NUM_CHANNELS-1:0] inc_s;
    logic [NUM_CHANNELS-1:0] at_max_s;
    logic [VEC_WIDTH-1:0]    rd_word_s;
    logic [VEC_WIDTH-1:0]    rd_data_r;
    logic                    rd_valid_r;

    // Per-channel increment qualification and next count value (wrap to 0 or hold at max).
    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (int'(sel_r[c]) < NUM_EVENTS) begin
                inc_s[c] = en_r[c] & evt_in[sel_r[c]] & ~freeze;
            end else begin
                inc_s[c] = 1'b0;
            end
            at_max_s[c] = (cnt_r[c] == CNT_MAX);
            if (at_max_s[c]) begin
                cnt_nxt_s[c] = sat_r[c] ? CNT_MAX : '0;
            end else begin
                cnt_nxt_s[c] = cnt_r[c] + CNT_WIDTH'(1'b1);
            end
        end
    end

    // Counters, shadows, overflow flags and channel configuration.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                cnt_r[c] <= '0;
                shd_r[c] <= '0;
                sel_r[c] <= '0;
            end
            en_r  <= '0;
            sat_r <= '0;
            ovf_r <= '0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                // Shadow capture uses the pre-edge value, so snapshot+clear keeps the old count.
                if (clear) begin
                    cnt_r[c] <= '0;
                    ovf_r[c] <= 1'b0;
                    shd_r[c] <= snapshot ? cnt_r[c] : '0;
                end else begin
                    if (snapshot) begin
                        shd_r[c] <= cnt_r[c];
                    end
                    if (inc_s[c]) begin
                        cnt_r[c] <= cnt_nxt_s[c];
                        if (at_max_s[c]) begin
                            ovf_r[c] <= 1'b1;
                        end
                    end
                end
                if (cfg_we && (int'(cfg_ch) == c)) begin
                    en_r[c]  <= cfg_en;
                    sat_r[c] <= cfg_sat;
                    sel_r[c] <= cfg_evt_sel;
                end
            end
        end
    end

    // Read mux: zero-extended live or shadow value, zero for a channel that does not exist.
    always_comb begin
        rd_word_s = '0;
        if (int'(rd_ch) < NUM_CHANNELS) begin
            rd_word_s[CNT_WIDTH-1:0] = rd_src ? shd_r[rd_ch] : cnt_r[rd_ch];
        end else begin
            rd_word_s = '0;
        end
    end

    // Registered read port: one-cycle latency, one valid pulse per request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_valid_r <= 1'b0;
            rd_data_r  <= '0;
        end else begin
            rd_valid_r <= rd_en;
            rd_data_r  <= rd_en ? rd_word_s : '0;
        end
    end

    assign rd_valid = rd_valid_r;
    assign rd_data  = rd_data_r;
    assign ovf      = ovf_r;

`ifdef PMC_THRESHOLD_IRQ_EN
    logic [CNT_WIDTH-1:0]    thr_r [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] irq_r;
    logic [NUM_CHANNELS-1:0] irq_set_s;

    // A zero threshold disables the IRQ for that channel.
    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            irq_set_s[c] = inc_s[c] & (thr_r[c] != '0) & (cnt_nxt_s[c] >= thr_r[c]);
        end
    end

    // Threshold registers and sticky IRQs; a new set condition beats a same-cycle ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                thr_r[c] <= '0;
            end
            irq_r <= '0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (thr_we && (int'(thr_ch) == c)) begin
                    thr_r[c] <= thr_val;
                end
                if (clear) begin
                    irq_r[c] <= 1'b0;
                end else begin
                    irq_r[c] <= irq_set_s[c] | (irq_r[c] & ~irq_ack[c]);
                end
            end
        end
    end

    assign irq = irq_r;
`else
    logic unused_thr_s;
    assign unused_thr_s = ^{thr_we, thr_ch, thr_val, irq_ack};
    assign irq = '0;
`endif

endmodule

// File: tb/tb_pmc_counter_bank.sv
// Self-checking bench for pmc_counter_bank: directed scenarios plus randomized traffic
// compared against an integer-level reference model of the counter bank.
module tb_pmc_counter_bank;

    localparam int NCH = 6;
    localparam int NEV = 6;
    localparam int CW  = 4;
    localparam int VW  = 64;
    localparam int CHW = 3;
    localparam int EVW = 3;
    localparam int MAXV = 15;
`ifdef PMC_THRESHOLD_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic [NEV-1:0] evt_in;
    logic           cfg_we;
    logic [CHW-1:0] cfg_ch;
    logic [EVW-1:0] cfg_evt_sel;
    logic           cfg_en, cfg_sat, freeze, clear, snapshot, rd_en, rd_src;
    logic [CHW-1:0] rd_ch;
    logic           rd_valid;
    logic [VW-1:0]  rd_data;
    logic [NCH-1:0] ovf, irq;
    logic           thr_we;
    logic [CHW-1:0] thr_ch;
    logic [CW-1:0]  thr_val;
    logic [NCH-1:0] irq_ack;

    int errors = 0;
    int checks = 0;

    // reference model state
    int m_cnt [NCH];
    int m_shd [NCH];
    int m_thr [NCH];
    int m_sel [NCH];
    bit m_en  [NCH];
    bit m_sat [NCH];
    bit m_ovf [NCH];
    bit m_irq [NCH];
    bit             exp_valid;
    logic [VW-1:0]  exp_data;

    pmc_counter_bank #(.NUM_CHANNELS(NCH), .NUM_EVENTS(NEV), .CNT_WIDTH(CW), .VEC_WIDTH(VW)) dut (
        .clk(clk), .reset(reset), .evt_in(evt_in), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_evt_sel(cfg_evt_sel), .cfg_en(cfg_en), .cfg_sat(cfg_sat), .freeze(freeze),
        .clear(clear), .snapshot(snapshot), .rd_en(rd_en), .rd_ch(rd_ch), .rd_src(rd_src),
        .rd_valid(rd_valid), .rd_data(rd_data), .ovf(ovf), .irq(irq), .thr_we(thr_we),
        .thr_ch(thr_ch), .thr_val(thr_val), .irq_ack(irq_ack)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_cnt[c] = 0; m_shd[c] = 0; m_thr[c] = 0; m_sel[c] = 0;
            m_en[c] = 0; m_sat[c] = 0; m_ovf[c] = 0; m_irq[c] = 0;
        end
        exp_valid = 0;
        exp_data  = '0;
    endfunction

    // One clock edge of the bank as described behaviourally.
    function automatic void model_edge();
        bit hit, set_irq;
        exp_valid = rd_en;
        exp_data  = '0;
        if (rd_en && int'(rd_ch) < NCH)
            exp_data = VW'(rd_src ? m_shd[rd_ch] : m_cnt[rd_ch]);
        for (int c = 0; c < NCH; c++) begin
            hit = 0;
            if (m_en[c] && !freeze && m_sel[c] < NEV) hit = evt_in[m_sel[c]];
            if (clear) begin
                m_shd[c] = snapshot ? m_cnt[c] : 0;
                m_cnt[c] = 0;
                m_ovf[c] = 0;
                m_irq[c] = 0;
            end else begin
                if (snapshot) m_shd[c] = m_cnt[c];
                set_irq = 0;
                if (hit) begin
                    if (m_cnt[c] + 1 > MAXV) begin
                        m_ovf[c] = 1;
                        m_cnt[c] = m_sat[c] ? MAXV : 0;
                    end else begin
                        m_cnt[c] = m_cnt[c] + 1;
                    end
                    set_irq = (m_thr[c] != 0) && (m_cnt[c] >= m_thr[c]);
                end
                if (IRQ_ON) m_irq[c] = set_irq || (m_irq[c] && !irq_ack[c]);
            end
        end
        if (cfg_we && int'(cfg_ch) < NCH) begin
            m_en[cfg_ch]  = cfg_en;
            m_sat[cfg_ch] = cfg_sat;
            m_sel[cfg_ch] = int'(cfg_evt_sel);
        end
        if (thr_we && int'(thr_ch) < NCH) m_thr[thr_ch] = int'(thr_val);
    endfunction

    function automatic logic [NCH-1:0] exp_ovf();
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = m_ovf[c];
        return v;
    endfunction

    function automatic logic [NCH-1:0] exp_irq();
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = m_irq[c];
        return v;
    endfunction

    task automatic idle();
        evt_in = '0; cfg_we = 0; cfg_ch = '0; cfg_evt_sel = '0; cfg_en = 0; cfg_sat = 0;
        freeze = 0; clear = 0; snapshot = 0; rd_en = 0; rd_ch = '0; rd_src = 0;
        thr_we = 0; thr_ch = '0; thr_val = '0; irq_ack = '0;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic configure(input int ch, input int sel, input bit en, input bit sat);
        cfg_we = 1; cfg_ch = CHW'(ch); cfg_evt_sel = EVW'(sel); cfg_en = en; cfg_sat = sat;
        step();
        cfg_we = 0;
    endtask

    task automatic read_ch(input int ch, input bit src, output logic [VW-1:0] data);
        rd_en = 1; rd_ch = CHW'(ch); rd_src = src;
        step();
        rd_en = 0;
        data = rd_data;
    endtask

    task automatic pulse_clear();
        clear = 1;
        step();
        clear = 0;
    endtask

    task automatic test_reset();
        logic [VW-1:0] d;
        checks += 4;
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %0b expected 0", rd_valid); end
        if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data: got %0h expected 0", rd_data); end
        if (ovf !== '0) begin errors++; $display("FAIL reset_ovf: got %0b expected 0", ovf); end
        if (irq !== '0) begin errors++; $display("FAIL reset_irq: got %0b expected 0", irq); end
        configure(0, 0, 1, 0);
        evt_in = 6'b000001;
        repeat (5) step();
        evt_in = '0;
        rd_en = 1; rd_ch = '0; rd_src = 0;
        step();
        rd_en = 0;
        checks += 2;
        if (rd_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %0b expected 1", rd_valid); end
        if (rd_data !== 64'd5) begin errors++; $display("FAIL pre_reset_count: got %0d expected 5", rd_data); end
        #3 reset = 0;
        model_reset();
        #1;
        checks += 2;
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid: got %0b expected 0", rd_valid); end
        if (rd_data !== '0) begin errors++; $display("FAIL async_reset_data: got %0h expected 0", rd_data); end
        @(posedge clk);
        #1 reset = 1;
        evt_in = 6'b000001;
        repeat (3) step();
        evt_in = '0;
        read_ch(0, 0, d);
        checks++;
        if (d !== '0) begin errors++; $display("FAIL reset_disables_ch0: got %0d expected 0", d); end
    endtask

    task automatic test_wrap_saturate();
        logic [VW-1:0] d;
        configure(1, 3, 1, 0);
        evt_in = 6'b001000;
        repeat (17) step();
        evt_in = '0;
        read_ch(1, 0, d);
        checks += 2;
        if (d !== 64'd1) begin errors++; $display("FAIL wrap_value: got %0d expected 1", d); end
        if (ovf[1] !== 1'b1) begin errors++; $display("FAIL wrap_ovf: got %0b expected 1", ovf[1]); end
        pulse_clear();
        checks++;
        if (ovf !== '0) begin errors++; $display("FAIL clear_ovf: got %0b expected 0", ovf); end
        configure(1, 3, 1, 1);
        evt_in = 6'b001000;
        repeat (17) step();
        evt_in = '0;
        read_ch(1, 0, d);
        checks += 2;
        if (d !== 64'd15) begin errors++; $display("FAIL sat_value: got %0d expected 15", d); end
        if (ovf[1] !== 1'b1) begin errors++; $display("FAIL sat_ovf: got %0b expected 1", ovf[1]); end
    endtask

    task automatic test_freeze_snapshot_clear();
        logic [VW-1:0] d;
        pulse_clear();
        configure(0, 0, 1, 0);
        evt_in = 6'b000001;
        repeat (10) step();
        evt_in = '0;
        snapshot = 1; clear = 1;
        step();
        snapshot = 0; clear = 0;
        read_ch(0, 1, d);
        checks++;
        if (d !== 64'd10) begin errors++; $display("FAIL snapshot_pre_clear: got %0d expected 10", d); end
        read_ch(0, 0, d);
        checks++;
        if (d !== 64'd0) begin errors++; $display("FAIL live_after_clear: got %0d expected 0", d); end
        freeze = 1;
        evt_in = 6'b000001;
        repeat (5) step();
        evt_in = '0;
        read_ch(0, 0, d);
        freeze = 0;
        checks++;
        if (d !== 64'd0) begin errors++; $display("FAIL freeze_hold: got %0d expected 0", d); end
        pulse_clear();
        read_ch(0, 1, d);
        checks++;
        if (d !== 64'd0) begin errors++; $display("FAIL clear_shadow: got %0d expected 0", d); end
    endtask

    task automatic test_config_race();
        logic [VW-1:0] d;
        configure(2, 0, 1, 0);
        cfg_we = 1; cfg_ch = 3'd2; cfg_evt_sel = 3'd1; cfg_en = 1; cfg_sat = 0;
        evt_in = 6'b000001;
        step();
        cfg_we = 0;
        step();
        evt_in = '0;
        read_ch(2, 0, d);
        checks++;
        if (d !== 64'd1) begin errors++; $display("FAIL config_race: got %0d expected 1", d); end
        configure(2, 7, 1, 0);
        evt_in = 6'b111111;
        repeat (3) step();
        evt_in = '0;
        read_ch(2, 0, d);
        checks++;
        if (d !== 64'd1) begin errors++; $display("FAIL bad_evt_sel: got %0d expected 1", d); end
    endtask

    task automatic test_back_to_back();
        int chans [3] = '{0, 2, 7};
        rd_src = 0;
        for (int i = 0; i < 3; i++) begin
            rd_en = 1; rd_ch = CHW'(chans[i]);
            step();
            checks += 2;
            if (rd_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %0b expected 1", i, rd_valid); end
            if (rd_data !== exp_data) begin errors++; $display("FAIL b2b_data[%0d]: got %0h expected %0h", i, rd_data, exp_data); end
        end
        checks++;
        if (rd_data !== '0) begin errors++; $display("FAIL b2b_oob_zero: got %0h expected 0", rd_data); end
        rd_en = 0;
        step();
        checks++;
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_drop: got %0b expected 0", rd_valid); end
    endtask

    task automatic test_irq();
        pulse_clear();
        configure(3, 4, 1, 0);
        thr_we = 1; thr_ch = 3'd3; thr_val = 4'd4;
        step();
        thr_we = 0;
        evt_in = 6'b010000;
        repeat (3) step();
        checks++;
        if (irq[3] !== 1'b0) begin errors++; $display("FAIL irq_below_thr: got %0b expected 0", irq[3]); end
        step();
        checks++;
        if (irq[3] !== IRQ_ON) begin errors++; $display("FAIL irq_at_thr: got %0b expected %0b", irq[3], IRQ_ON); end
        irq_ack = 6'b001000;
        step();
        checks++;
        if (irq[3] !== IRQ_ON) begin errors++; $display("FAIL irq_ack_race: got %0b expected %0b", irq[3], IRQ_ON); end
        evt_in = '0;
        step();
        irq_ack = '0;
        checks++;
        if (irq[3] !== 1'b0) begin errors++; $display("FAIL irq_ack_clear: got %0b expected 0", irq[3]); end
        thr_we = 1; thr_ch = 3'd3; thr_val = 4'd0;
        step();
        idle();
    endtask

    task automatic test_random();
        pulse_clear();
        for (int n = 0; n < 400; n++) begin
            evt_in      = NEV'($urandom);
            freeze      = ($urandom_range(0, 7) == 0);
            clear       = ($urandom_range(0, 40) == 0);
            snapshot    = ($urandom_range(0, 7) == 0);
            cfg_we      = ($urandom_range(0, 4) == 0);
            cfg_ch      = CHW'($urandom_range(0, 7));
            cfg_evt_sel = EVW'($urandom_range(0, 7));
            cfg_en      = ($urandom_range(0, 3) != 0);
            cfg_sat     = $urandom_range(0, 1) == 1;
            rd_en       = $urandom_range(0, 1) == 1;
            rd_ch       = CHW'($urandom_range(0, 7));
            rd_src      = $urandom_range(0, 1) == 1;
            thr_we      = ($urandom_range(0, 9) == 0);
            thr_ch      = CHW'($urandom_range(0, 7));
            thr_val     = CW'($urandom_range(0, 15));
            irq_ack     = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '0;
            step();
            checks += 3;
            if (rd_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid@%0d: got %0b expected %0b", n, rd_valid, exp_valid); end
            if (ovf !== exp_ovf()) begin errors++; $display("FAIL rnd_ovf@%0d: got %0b expected %0b", n, ovf, exp_ovf()); end
            if (irq !== exp_irq()) begin errors++; $display("FAIL rnd_irq@%0d: got %0b expected %0b", n, irq, exp_irq()); end
            if (exp_valid) begin
                checks++;
                if (rd_data !== exp_data) begin errors++; $display("FAIL rnd_data@%0d: got %0h expected %0h", n, rd_data, exp_data); end
            end
        end
        idle();
    endtask

    initial begin
        reset = 0;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1;
        test_reset();
        test_wrap_saturate();
        test_freeze_snapshot_clear();
        test_config_race();
        test_back_to_back();
        test_irq();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
